// File: rtl/rv32_pkg.sv
// Shared RV32 constants and the register-file arbiter state encoding.
package rv32_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      RD1,
      RD2,
      CAP,
      RSP
   } arb_state_t;

endpackage

// File: rtl/regfile_arbiter.sv
// Arbitrates one writeback port and one two-operand decode read onto a single-ported register file.
// Define REGFILE_ARB_RR_EN for round-robin on simultaneous requests; otherwise writes always win.
module regfile_arbiter
   import rv32_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [REG_ADDR_W-1:0] wr_addr,
   input  logic [XLEN-1:0]       wr_data,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [XLEN-1:0]       rs1_data,
   output logic [XLEN-1:0]       rs2_data,
   output logic [REG_ADDR_W-1:0] rf_regno,
   output logic [XLEN-1:0]       rf_wdata,
   output logic                  rf_read,
   output logic                  rf_write,
   input  logic [XLEN-1:0]       rf_rdata
);

   arb_state_t            state, next_state;
   logic [REG_ADDR_W-1:0] wr_addr_q, rs1_q, rs2_q;
   logic [XLEN-1:0]       wr_data_q;
   logic                  grant_wr, grant_rd;
`ifdef REGFILE_ARB_RR_EN
   logic                  last_rd;
`endif

   // Grants only in IDLE and never while reset is asserted, so a requester
   // cannot see a handshake that the reset is about to discard.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (state == IDLE && !rst) begin
         if (wr_valid && rd_valid) begin
`ifdef REGFILE_ARB_RR_EN
            grant_wr = last_rd;
            grant_rd = !last_rd;
`else
            grant_wr = 1'b1;
`endif
         end else begin
            grant_wr = wr_valid;
            grant_rd = rd_valid;
         end
      end
   end

   assign wr_ready = grant_wr;
   assign rd_ready = grant_rd;

   always_comb begin
      next_state = state;
      rf_read    = 1'b0;
      rf_write   = 1'b0;
      rf_regno   = '0;
      rf_wdata   = '0;
      rsp_valid  = 1'b0;
      case (state)
         IDLE: begin
            if (grant_wr)      next_state = WRITE;
            else if (grant_rd) next_state = RD1;
         end
         WRITE: begin
            // x0 is hardwired zero: the write is consumed but never reaches the file.
            rf_write   = (wr_addr_q != '0);
            rf_regno   = wr_addr_q;
            rf_wdata   = wr_data_q;
            next_state = IDLE;
         end
         RD1: begin
            rf_read    = 1'b1;
            rf_regno   = rs1_q;
            next_state = RD2;
         end
         RD2: begin
            rf_read    = 1'b1;
            rf_regno   = rs2_q;
            next_state = CAP;
         end
         CAP: next_state = RSP;
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state     <= IDLE;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rs1_data  <= '0;
         rs2_data  <= '0;
`ifdef REGFILE_ARB_RR_EN
         last_rd   <= 1'b1;
`endif
      end else begin
         state <= next_state;
         if (grant_wr) begin
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
         end
         if (grant_rd) begin
            rs1_q <= rs1;
            rs2_q <= rs2;
         end
         // rf_rdata lags rf_read by one cycle: RD2 sees rs1's value, CAP sees rs2's.
         if (state == RD2) rs1_data <= (rs1_q == '0) ? '0 : rf_rdata;
         if (state == CAP) rs2_data <= (rs2_q == '0) ? '0 : rf_rdata;
`ifdef REGFILE_ARB_RR_EN
         if (grant_wr)      last_rd <= 1'b0;
         else if (grant_rd) last_rd <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register file beside it.
// Honours REGFILE_ARB_RR_EN for the simultaneous-request expectations.
module tb_regfile_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid, rd_valid, rsp_ready;
   logic        wr_ready, rd_ready, rsp_valid;
   logic [4:0]  wr_addr, rs1, rs2, rf_regno;
   logic [31:0] wr_data, rs1_data, rs2_data, rf_wdata, rf_rdata;
   logic        rf_read, rf_write;

   int          vecs = 0;
   int          errs = 0;
   logic [31:0] rf_mem [32];
   logic [31:0] exp_rf [32];
   logic        both_seen = 1'b0;
   logic        x0_seen   = 1'b0;

   wire [105:0] outs = {wr_ready, rd_ready, rsp_valid, rf_read, rf_write,
                        rf_regno, rf_wdata, rs1_data, rs2_data};

   always #5 clk = ~clk;

   regfile_arbiter dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rs1(rs1), .rs2(rs2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rf_regno(rf_regno), .rf_wdata(rf_wdata),
      .rf_read(rf_read), .rf_write(rf_write), .rf_rdata(rf_rdata)
   );

   // Register file: synchronous write, data returned the cycle after rf_read.
   always @(posedge clk) begin
      if (rf_write) rf_mem[rf_regno] <= rf_wdata;
      if (rf_read)  rf_rdata <= rf_mem[rf_regno];
      if (rf_read && rf_write) both_seen <= 1'b1;
      if (rf_write && rf_regno == 5'd0) x0_seen <= 1'b1;
   end

   function automatic logic [31:0] exp_val(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : exp_rf[a];
   endfunction

   // Waits (bounded) for the response, checks its latency from RD1, then consumes it.
   task automatic wait_rsp(input int exp_lat, output logic [31:0] d1, output logic [31:0] d2);
      int n = 0;
      while (!rsp_valid && n < 12) begin
         @(negedge clk); #1; n++;
      end
      vecs++;
      if (rsp_valid !== 1'b1 || n != exp_lat) begin
         $display("FAIL rsp_latency: rsp_valid=%b after %0d cycles, required 1 after %0d", rsp_valid, n, exp_lat);
         errs++;
      end
      d1 = rs1_data;
      d2 = rs2_data;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      vecs++;
      if (rsp_valid !== 1'b0) begin
         $display("FAIL rsp_drop: rsp_valid=%b, required 0", rsp_valid);
         errs++;
      end
   endtask

   task automatic write_op(input logic [4:0] a, input logic [31:0] d);
      int n = 0;
      @(negedge clk);
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      #1;
      while (!wr_ready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      vecs++;
      if (wr_ready !== 1'b1) begin
         $display("FAIL wr_accept: wr_ready=%b, required 1", wr_ready);
         errs++;
      end
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      vecs++;
      if (a == 5'd0) begin
         if (rf_write !== 1'b0) begin
            $display("FAIL wr_x0_strobe: rf_write=%b, required 0", rf_write);
            errs++;
         end
      end else if ({rf_write, rf_read, rf_regno, rf_wdata} !== {1'b1, 1'b0, a, d}) begin
         $display("FAIL wr_strobe: write=%b read=%b regno=%0d wdata=%h, required 1 0 %0d %h",
                  rf_write, rf_read, rf_regno, rf_wdata, a, d);
         errs++;
      end
      if (a != 5'd0) exp_rf[a] = d;
   endtask

   task automatic read_op(input logic [4:0] a1, input logic [4:0] a2,
                          output logic [31:0] d1, output logic [31:0] d2);
      int n = 0;
      @(negedge clk);
      rd_valid = 1'b1; rs1 = a1; rs2 = a2;
      #1;
      while (!rd_ready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      vecs++;
      if (rd_ready !== 1'b1) begin
         $display("FAIL rd_accept: rd_ready=%b, required 1", rd_ready);
         errs++;
      end
      @(negedge clk);
      rd_valid = 1'b0;
      #1;
      wait_rsp(3, d1, d2);
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0;
      wr_addr = '0; wr_data = '0; rs1 = '0; rs2 = '0;
      repeat (2) @(negedge clk);
      wr_valid = 1'b1; rd_valid = 1'b1;
      #1;
      vecs++;
      if ({wr_ready, rd_ready} !== 2'b00) begin
         $display("FAIL reset_ready: wr_ready=%b rd_ready=%b, required 0 0", wr_ready, rd_ready);
         errs++;
      end
      @(negedge clk);
      wr_valid = 1'b0; rd_valid = 1'b0; rst = 1'b0;
      #1;
      vecs++;
      if (outs !== '0) begin
         $display("FAIL reset_outputs: got %h, required 0", outs);
         errs++;
      end
   endtask

   task automatic test_write_read();
      logic [31:0] d1, d2;
      write_op(5'd5, 32'hDEADBEEF);
      read_op(5'd5, 5'd0, d1, d2);
      vecs++;
      if ({d1, d2} !== {32'hDEADBEEF, 32'h0}) begin
         $display("FAIL write_read: rs1_data=%h rs2_data=%h, required deadbeef 00000000", d1, d2);
         errs++;
      end
   endtask

   task automatic test_x0();
      logic [31:0] d1, d2;
      write_op(5'd0, 32'h00001234);
      read_op(5'd0, 5'd5, d1, d2);
      vecs++;
      if ({d1, d2} !== {32'h0, 32'hDEADBEEF}) begin
         $display("FAIL x0_read: rs1_data=%h rs2_data=%h, required 00000000 deadbeef", d1, d2);
         errs++;
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] d1, d2;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
      rd_valid = 1'b1; rs1 = 5'd7; rs2 = 5'd5;
      #1;
      vecs++;
      if ({wr_ready, rd_ready} !== 2'b10) begin
         $display("FAIL simul_grant1: wr_ready=%b rd_ready=%b, required 1 0", wr_ready, rd_ready);
         errs++;
      end
      @(negedge clk);
      wr_addr = 5'd8; wr_data = 32'h22;
      #1;
      vecs++;
      if ({wr_ready, rd_ready, rf_write, rf_regno} !== {3'b001, 5'd7}) begin
         $display("FAIL simul_write1: wr_ready=%b rd_ready=%b rf_write=%b regno=%0d, required 0 0 1 7",
                  wr_ready, rd_ready, rf_write, rf_regno);
         errs++;
      end
      exp_rf[7] = 32'h11;
      @(negedge clk); #1;
`ifdef REGFILE_ARB_RR_EN
      vecs++;
      if ({wr_ready, rd_ready} !== 2'b01) begin
         $display("FAIL simul_grant2: wr_ready=%b rd_ready=%b, required 0 1", wr_ready, rd_ready);
         errs++;
      end
      @(negedge clk); rd_valid = 1'b0; #1;
      wait_rsp(3, d1, d2);
      vecs++;
      if (wr_ready !== 1'b1) begin
         $display("FAIL simul_late_write: wr_ready=%b, required 1", wr_ready);
         errs++;
      end
      @(negedge clk); wr_valid = 1'b0; #1;
      vecs++;
      if ({rf_write, rf_regno, rf_wdata} !== {1'b1, 5'd8, 32'h22}) begin
         $display("FAIL simul_write2: rf_write=%b regno=%0d wdata=%h, required 1 8 00000022",
                  rf_write, rf_regno, rf_wdata);
         errs++;
      end
`else
      vecs++;
      if ({wr_ready, rd_ready} !== 2'b10) begin
         $display("FAIL simul_grant2: wr_ready=%b rd_ready=%b, required 1 0", wr_ready, rd_ready);
         errs++;
      end
      @(negedge clk); wr_valid = 1'b0; #1;
      vecs++;
      if ({rf_write, rf_regno, rf_wdata} !== {1'b1, 5'd8, 32'h22}) begin
         $display("FAIL simul_write2: rf_write=%b regno=%0d wdata=%h, required 1 8 00000022",
                  rf_write, rf_regno, rf_wdata);
         errs++;
      end
      @(negedge clk); #1;
      vecs++;
      if (rd_ready !== 1'b1) begin
         $display("FAIL simul_late_read: rd_ready=%b, required 1", rd_ready);
         errs++;
      end
      @(negedge clk); rd_valid = 1'b0; #1;
      wait_rsp(3, d1, d2);
`endif
      exp_rf[8] = 32'h22;
      vecs++;
      if ({d1, d2} !== {32'h11, 32'hDEADBEEF}) begin
         $display("FAIL simul_read: rs1_data=%h rs2_data=%h, required 00000011 deadbeef", d1, d2);
         errs++;
      end
   endtask

   task automatic test_stall();
      int n = 0;
      @(negedge clk);
      rd_valid = 1'b1; rs1 = 5'd8; rs2 = 5'd7;
      #1;
      vecs++;
      if (rd_ready !== 1'b1) begin
         $display("FAIL stall_accept: rd_ready=%b, required 1", rd_ready);
         errs++;
      end
      @(negedge clk); #1;
      while (!rsp_valid && n < 12) begin
         @(negedge clk); #1; n++;
      end
      // Fresh requests from both sides must be held off while the response stalls.
      wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
      rd_valid = 1'b1; rs1 = 5'd1; rs2 = 5'd2;
      for (int c = 0; c < 5; c++) begin
         #1;
         vecs++;
         if ({rsp_valid, rs1_data, rs2_data, wr_ready, rd_ready} !== {1'b1, 32'h22, 32'h11, 2'b00}) begin
            $display("FAIL stall_hold[%0d]: rsp_valid=%b rs1=%h rs2=%h wr_ready=%b rd_ready=%b, required 1 00000022 00000011 0 0",
                     c, rsp_valid, rs1_data, rs2_data, wr_ready, rd_ready);
            errs++;
         end
         @(negedge clk);
      end
      wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      vecs++;
      if (rsp_valid !== 1'b0) begin
         $display("FAIL stall_release: rsp_valid=%b, required 0", rsp_valid);
         errs++;
      end
   endtask

   task automatic test_reset_mid();
      logic seen = 1'b0;
      @(negedge clk);
      rd_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd7;
      @(negedge clk); rd_valid = 1'b0;
      @(negedge clk); #1;
      vecs++;
      if ({rf_read, rf_regno} !== {1'b1, 5'd7}) begin
         $display("FAIL rstmid_rd2: rf_read=%b regno=%0d, required 1 7", rf_read, rf_regno);
         errs++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      vecs++;
      if (outs !== '0) begin
         $display("FAIL rstmid_outputs: got %h, required 0", outs);
         errs++;
      end
      repeat (8) begin
         @(negedge clk); #1;
         if (rsp_valid) seen = 1'b1;
      end
      vecs++;
      if (seen !== 1'b0) begin
         $display("FAIL rstmid_no_rsp: rsp_valid seen=%b, required 0", seen);
         errs++;
      end
   endtask

   task automatic test_random_traffic();
      logic [31:0] d1, d2;
      logic [4:0]  a1, a2;
      for (int i = 0; i < 40; i++) begin
         a1 = 5'($urandom_range(0, 31));
         a2 = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 0) begin
            write_op(a1, $urandom);
         end else begin
            read_op(a1, a2, d1, d2);
            vecs++;
            if ({d1, d2} !== {exp_val(a1), exp_val(a2)}) begin
               $display("FAIL random_read[%0d]: x%0d=%h x%0d=%h, required %h %h",
                        i, a1, d1, a2, d2, exp_val(a1), exp_val(a2));
               errs++;
            end
         end
      end
      vecs++;
      if ({both_seen, x0_seen} !== 2'b00) begin
         $display("FAIL strobe_rules: read&write overlap=%b x0 write=%b, required 0 0", both_seen, x0_seen);
         errs++;
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf_mem[i] = 32'h0;
         exp_rf[i] = 32'h0;
      end
      // Garbage in x0 storage proves the arbiter forces zero instead of trusting the file.
      rf_mem[0] = 32'hBAD0BAD0;
      test_reset();
      test_write_read();
      test_x0();
      test_simultaneous();
      test_stall();
      test_reset_mid();
      test_random_traffic();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
